stream_arb2: RTL and testbench

STREAM_ARB2 -- requirements
Module: stream_arb2

---
 rtl/stream_pkg.sv | 10 +
 rtl/stream_arb2_if.sv | 35 +++
 rtl/stream_arb2_mux.sv | 13 +
 rtl/stream_arb2.sv | 83 ++++++++
 tb/tb_stream_arb2.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/stream_pkg.sv
// Shared constants for the two-input stream arbiter and its testbench.
package stream_pkg;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_CNT_W = 16;

endpackage

// File: rtl/stream_arb2_if.sv
// Bundles both input channels, the output channel and the grant counters of stream_arb2.
interface stream_arb2_if
   import stream_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CNT_W = DEF_CNT_W
) ();

   logic [WIDTH-1:0] a_data;
   logic             a_valid;
   logic             a_ready;
   logic [WIDTH-1:0] b_data;
   logic             b_valid;
   logic             b_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_sel;
   logic             out_valid;
   logic             out_ready;
   logic             clr;
   logic [CNT_W-1:0] cnt_a;
   logic [CNT_W-1:0] cnt_b;

   // Arbiter side
   modport slave (
      input  a_data, a_valid, b_data, b_valid, out_ready, clr,
      output a_ready, b_ready, out_data, out_sel, out_valid, cnt_a, cnt_b
   );

   // Producer/consumer side
   modport master (
      output a_data, a_valid, b_data, b_valid, out_ready, clr,
      input  a_ready, b_ready, out_data, out_sel, out_valid, cnt_a, cnt_b
   );

endinterface

// File: rtl/stream_arb2_mux.sv
// Shared 2:1 WIDTH-wide multiplexer; sel=0 passes d0, sel=1 passes d1.
module mux #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   output logic [WIDTH-1:0] y_c
);

   assign y_c = sel ? d1 : d0;

endmodule

// File: rtl/stream_arb2.sv
// Round-robin 2:1 stream arbiter with a one-entry output register and
// saturating per-source grant counters.
module stream_arb2
   import stream_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   stream_arb2_if.slave bus
);

   logic             free;
   logic             grant_b;
   logic             sel;
   logic             a_hs;
   logic             b_hs;
   logic [WIDTH-1:0] mux_y;

   logic             last_grant;
   logic [WIDTH-1:0] data_q;
   logic             sel_q;
   logic             valid_q;
   logic [CNT_W-1:0] cnt_a_q;
   logic [CNT_W-1:0] cnt_b_q;

   // Grant decision: B wins only when A is idle or A was granted last
   always_comb begin
      free    = ~valid_q | bus.out_ready;
      grant_b = bus.b_valid & (~bus.a_valid | (last_grant == SEL_A));
      sel     = grant_b ? SEL_B : SEL_A;
      a_hs    = ~rst & free & bus.a_valid & ~grant_b;
      b_hs    = ~rst & free & grant_b;
   end

   mux #(.WIDTH(WIDTH)) u_mux (
      .sel (sel),
      .d0  (bus.a_data),
      .d1  (bus.b_data),
      .y_c (mux_y)
   );

   // Output register, round-robin pointer and grant counters
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q     <= '0;
         sel_q      <= SEL_A;
         valid_q    <= 1'b0;
         last_grant <= SEL_B;
         cnt_a_q    <= '0;
         cnt_b_q    <= '0;
      end else begin
         if (free) begin
            if (a_hs | b_hs) begin
               data_q     <= mux_y;
               sel_q      <= sel;
               valid_q    <= 1'b1;
               last_grant <= sel;
            end else begin
               valid_q <= 1'b0;
            end
         end
         // clr wins over a same-cycle increment
         if (bus.clr) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
         end else begin
            if (a_hs && (cnt_a_q != '1)) cnt_a_q <= cnt_a_q + CNT_W'(1);
            if (b_hs && (cnt_b_q != '1)) cnt_b_q <= cnt_b_q + CNT_W'(1);
         end
      end
   end

   assign bus.a_ready   = a_hs;
   assign bus.b_ready   = b_hs;
   assign bus.out_data  = data_q;
   assign bus.out_sel   = sel_q;
   assign bus.out_valid = valid_q;
   assign bus.cnt_a     = cnt_a_q;
   assign bus.cnt_b     = cnt_b_q;

endmodule

// File: tb/tb_stream_arb2.sv
// Self-checking bench for stream_arb2: vector table, corner sequences and a
// randomized run checked by a per-source scoreboard.
module tb_stream_arb2;
   import stream_pkg::*;

   localparam int unsigned W   = 8;
   localparam int unsigned CW  = 16;
   localparam int unsigned CW2 = 2;
   localparam logic L = 1'b0;
   localparam logic H = 1'b1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   stream_arb2_if #(.WIDTH(W), .CNT_W(CW))  bus  ();
   stream_arb2_if #(.WIDTH(W), .CNT_W(CW2)) bus2 ();

   stream_arb2 #(.WIDTH(W), .CNT_W(CW))  dut  (.clk(clk), .rst(rst), .bus(bus.slave));
   stream_arb2 #(.WIDTH(W), .CNT_W(CW2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic       rst, av;
      logic [7:0] ad;
      logic       bv;
      logic [7:0] bd;
      logic       ordy, clr;
      logic       ear, ebr, eov;
      logic [7:0] eod;
      logic       eos;
      logic [15:0] eca, ecb;
   } vec_t;

   vec_t vt[16];

   // Scoreboard: accepted words queued per source, popped when emitted
   logic [7:0] qa[$];
   logic [7:0] qb[$];

   always @(negedge clk) begin
      if (rst) begin
         qa.delete();
         qb.delete();
      end else begin
         check("ready_excl", 32'(bus.a_ready & bus.b_ready), 32'd0);
         if (bus.out_valid && bus.out_ready) begin
            if (bus.out_sel == SEL_A) begin
               if (qa.size() == 0) check("sb_extra_a", 32'(bus.out_data), 32'hFFFF_FFFF);
               else                check("sb_word_a", 32'(bus.out_data), 32'(qa.pop_front()));
            end else begin
               if (qb.size() == 0) check("sb_extra_b", 32'(bus.out_data), 32'hFFFF_FFFF);
               else                check("sb_word_b", 32'(bus.out_data), 32'(qb.pop_front()));
            end
         end
         if (bus.a_valid && bus.a_ready) qa.push_back(bus.a_data);
         if (bus.b_valid && bus.b_ready) qb.push_back(bus.b_data);
      end
   end

   task automatic drive(input logic r, input logic av, input logic [7:0] ad,
                        input logic bv, input logic [7:0] bd,
                        input logic ordy, input logic c);
      rst           = r;
      bus.a_valid   = av;
      bus.a_data    = ad;
      bus.b_valid   = bv;
      bus.b_data    = bd;
      bus.out_ready = ordy;
      bus.clr       = c;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic       pend_a, pend_b;
   int         hs_a, hs_b;
   logic [1:0] exp36[5];

   initial begin
      drive(H, L, 8'h00, L, 8'h00, L, L);
      bus2.a_valid = 1'b0; bus2.a_data = '0; bus2.b_valid = 1'b0; bus2.b_data = '0;
      bus2.out_ready = 1'b0; bus2.clr = 1'b0;

      //         rst av  ad     bv  bd     ordy clr  ear ebr eov eod    eos eca     ecb
      vt[0]  = '{L, H, 8'h11, L, 8'h00, H, L,  H, L, H, 8'h11, L, 16'd1, 16'd0};
      vt[1]  = '{H, H, 8'hAA, H, 8'hBB, H, L,  L, L, L, 8'h00, L, 16'd0, 16'd0};
      vt[2]  = '{L, H, 8'hAA, H, 8'hBB, H, L,  H, L, H, 8'hAA, L, 16'd1, 16'd0};
      vt[3]  = '{L, H, 8'hAA, H, 8'hBB, H, L,  L, H, H, 8'hBB, H, 16'd1, 16'd1};
      vt[4]  = '{L, H, 8'hAA, H, 8'hBB, H, L,  H, L, H, 8'hAA, L, 16'd2, 16'd1};
      vt[5]  = '{L, H, 8'hAA, H, 8'hBB, H, L,  L, H, H, 8'hBB, H, 16'd2, 16'd2};
      vt[6]  = '{L, H, 8'hAA, H, 8'hBB, L, L,  L, L, H, 8'hBB, H, 16'd2, 16'd2};
      vt[7]  = '{L, H, 8'hAA, H, 8'hBB, L, L,  L, L, H, 8'hBB, H, 16'd2, 16'd2};
      vt[8]  = '{L, H, 8'hAA, H, 8'hBB, L, L,  L, L, H, 8'hBB, H, 16'd2, 16'd2};
      vt[9]  = '{L, H, 8'hAA, H, 8'hBB, H, L,  H, L, H, 8'hAA, L, 16'd3, 16'd2};
      vt[10] = '{L, L, 8'h00, L, 8'h00, H, L,  L, L, L, 8'hAA, L, 16'd3, 16'd2};
      vt[11] = '{L, L, 8'h00, H, 8'h5C, L, L,  L, H, H, 8'h5C, H, 16'd3, 16'd3};
      vt[12] = '{L, H, 8'h33, L, 8'h00, H, H,  H, L, H, 8'h33, L, 16'd0, 16'd0};
      vt[13] = '{L, L, 8'h00, L, 8'h00, L, L,  L, L, H, 8'h33, L, 16'd0, 16'd0};
      vt[14] = '{L, L, 8'h00, H, 8'h77, L, L,  L, L, H, 8'h33, L, 16'd0, 16'd0};
      vt[15] = '{L, L, 8'h00, H, 8'h77, H, L,  L, H, H, 8'h77, H, 16'd0, 16'd1};

      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data",  32'(bus.out_data),  32'd0);
      check("rst_out_sel",   32'(bus.out_sel),   32'd0);
      check("rst_cnt_a",     32'(bus.cnt_a),     32'd0);
      check("rst_cnt_b",     32'(bus.cnt_b),     32'd0);

      for (int i = 0; i < 16; i++) begin
         drive(vt[i].rst, vt[i].av, vt[i].ad, vt[i].bv, vt[i].bd, vt[i].ordy, vt[i].clr);
         #1;
         check($sformatf("v%0d_a_ready", i), 32'(bus.a_ready), 32'(vt[i].ear));
         check($sformatf("v%0d_b_ready", i), 32'(bus.b_ready), 32'(vt[i].ebr));
         tick();
         check($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vt[i].eov));
         check($sformatf("v%0d_out_data", i),  32'(bus.out_data),  32'(vt[i].eod));
         check($sformatf("v%0d_out_sel", i),   32'(bus.out_sel),   32'(vt[i].eos));
         check($sformatf("v%0d_cnt_a", i),     32'(bus.cnt_a),     32'(vt[i].eca));
         check($sformatf("v%0d_cnt_b", i),     32'(bus.cnt_b),     32'(vt[i].ecb));
      end

      // Reset while a word is stalled at the output
      drive(L, H, 8'h44, L, 8'h00, H, L);
      tick();
      drive(H, H, 8'h45, H, 8'h46, L, L);
      #1;
      check("rstflight_a_ready", 32'(bus.a_ready), 32'd0);
      check("rstflight_b_ready", 32'(bus.b_ready), 32'd0);
      tick();
      check("rstflight_out_valid", 32'(bus.out_valid), 32'd0);
      check("rstflight_cnt_a",     32'(bus.cnt_a),     32'd0);
      check("rstflight_cnt_b",     32'(bus.cnt_b),     32'd0);
      drive(L, H, 8'hAA, H, 8'hBB, L, L);
      #1;
      check("first_tie_a_ready", 32'(bus.a_ready), 32'd1);
      check("first_tie_b_ready", 32'(bus.b_ready), 32'd0);
      tick();
      check("first_tie_sel",  32'(bus.out_sel),  32'(SEL_A));
      check("first_tie_data", 32'(bus.out_data), 32'hAA);
      drive(L, L, 8'h00, L, 8'h00, H, L);

      // Counter saturation and clr override on the narrow-counter instance
      exp36 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      bus2.out_ready = 1'b1;
      bus2.a_valid   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus2.a_data = 8'(8'h60 + i);
         tick();
         check($sformatf("sat_cnt_a_%0d", i), 32'(bus2.cnt_a), 32'(exp36[i]));
      end
      bus2.a_data = 8'h6F;
      bus2.clr    = 1'b1;
      #1;
      check("clr_hs_a_ready", 32'(bus2.a_ready), 32'd1);
      tick();
      check("clr_cnt_a",    32'(bus2.cnt_a),    32'd0);
      check("clr_out_data", 32'(bus2.out_data), 32'h6F);
      bus2.clr     = 1'b0;
      bus2.a_valid = 1'b0;

      // Randomized traffic with well-behaved sources
      drive(H, L, 8'h00, L, 8'h00, H, L);
      tick();
      rst = 1'b0;
      pend_a = 1'b0; pend_b = 1'b0; hs_a = 0; hs_b = 0;
      for (int n = 0; n < 10000; n++) begin
         if (!pend_a) begin
            bus.a_valid = ($urandom_range(0, 9) < 6);
            bus.a_data  = 8'($urandom);
         end
         if (!pend_b) begin
            bus.b_valid = ($urandom_range(0, 9) < 6);
            bus.b_data  = 8'($urandom);
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         pend_a = bus.a_valid && !bus.a_ready;
         pend_b = bus.b_valid && !bus.b_ready;
         if (bus.a_valid && bus.a_ready) hs_a++;
         if (bus.b_valid && bus.b_ready) hs_b++;
         tick();
      end
      drive(L, L, 8'h00, L, 8'h00, H, L);
      repeat (3) tick();
      check("rand_cnt_a",   32'(bus.cnt_a), 32'(hs_a));
      check("rand_cnt_b",   32'(bus.cnt_b), 32'(hs_b));
      check("rand_left_a",  32'(qa.size()), 32'd0);
      check("rand_left_b",  32'(qb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
